// File: rtl/ct_fadd_h_pkg.sv
// Shared FP16 adder definitions: rounding modes, field widths, constants,
// the stage-1 bundle and a one-hot to shift-amount helper.
package ct_fadd_h_pkg;

    localparam int EXP_W  = 5;
    localparam int FRAC_W = 10;
    localparam int MANT_W = 12;

    localparam logic [15:0] FP16_INF  = 16'h7C00;
    localparam logic [15:0] FP16_MAXN = 16'h7BFF;

    typedef enum logic [2:0] {
        RM_RNE = 3'd0,
        RM_RTZ = 3'd1,
        RM_RDN = 3'd2,
        RM_RUP = 3'd3,
        RM_RMM = 3'd4
    } rm_e;

    typedef struct packed {
        logic [MANT_W-1:0] mant;
        logic              sticky;
        logic [EXP_W:0]    expnt;
        logic [MANT_W-1:0] onehot;
        logic              den;
        logic              sign;
        logic              eff_sub;
        logic [2:0]        rm;
    } s1_t;

    function automatic logic [3:0] oh2amt(input logic [MANT_W-1:0] oh);
        oh2amt = '0;
        for (int i = 0; i < MANT_W; i++)
            if (oh[i]) oh2amt = 4'(MANT_W - 1 - i);
    endfunction

endpackage

// File: rtl/ct_fadd_lzd_h.sv
// Leading-one detector for the 12-bit significand; the shift is clamped
// so the exponent never drops below 1, flagging a denormal result.
module ct_fadd_lzd_h
    import ct_fadd_h_pkg::*;
(
    input  logic [MANT_W-1:0] i_mant,
    input  logic [EXP_W-1:0]  i_expnt,
    output logic [MANT_W-1:0] o_onehot,
    output logic              o_den
);

    logic [3:0]       w_pos;
    logic             w_any;
    logic [3:0]       w_shift;
    logic [EXP_W-1:0] w_limit;

    always_comb begin
        w_pos = '0;
        w_any = 1'b0;
        for (int i = 0; i < MANT_W; i++) begin
            if (i_mant[i]) begin
                w_pos = 4'(i);
                w_any = 1'b1;
            end
        end
        w_shift  = 4'd11 - w_pos;
        w_limit  = (i_expnt == '0) ? '0 : i_expnt - 5'd1;
        o_onehot = '0;
        o_den    = 1'b0;
        if (w_any) begin
            if ({1'b0, w_shift} > w_limit) begin
                o_onehot[4'd11 - w_limit[3:0]] = 1'b1;
                o_den = 1'b1;
            end else begin
                o_onehot[w_pos] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ct_fadd_ohsel_h.sv
// One-hot shift selector: left shift by (11 - position of the set bit),
// zero-filling from below; an all-zero select yields zero.
module ct_fadd_ohsel_h
    import ct_fadd_h_pkg::*;
(
    input  logic [MANT_W-1:0] i_data,
    input  logic [MANT_W-1:0] i_onehot,
    output logic [MANT_W-1:0] o_data
);

    always_comb begin
        o_data = '0;
        for (int k = 0; k < MANT_W; k++)
            if (i_onehot[MANT_W-1-k]) o_data = o_data | (i_data << k);
    end

endmodule

// File: rtl/ct_fadd_norm_round_h.sv
// FP16 adder back end: stage 1 leading-one/limit detect, stage 2
// shift, round, overflow/underflow handling and pack.
module ct_fadd_norm_round_h
    import ct_fadd_h_pkg::*;
(
    input  logic        cpuclk,
    input  logic        cpurst_b,
    input  logic        pipe_stall,
    input  logic        pipe_flush,
    input  logic        in_vld,
    input  logic        in_sign,
    input  logic        in_eff_sub,
    input  logic [4:0]  in_expnt,
    input  logic [12:0] in_mant,
    input  logic        in_sticky,
    input  logic [2:0]  in_rm,
    output logic        out_vld,
    output logic [15:0] out_result,
    output logic [2:0]  out_flags
);

    logic              r_s1_vld;
    logic              r_s2_vld;
    s1_t               r_s1;
    logic [15:0]       r_res;
    logic [2:0]        r_flags;

    s1_t               w_s1_nxt;
    logic [MANT_W-1:0] w_lzd_oh;
    logic              w_lzd_den;

    ct_fadd_lzd_h u_lzd (
        .i_mant   (in_mant[11:0]),
        .i_expnt  (in_expnt),
        .o_onehot (w_lzd_oh),
        .o_den    (w_lzd_den)
    );

    // A carry-out is a 1-bit right shift; bit 0 folds into sticky.
    always_comb begin
        w_s1_nxt         = '0;
        w_s1_nxt.sign    = in_sign;
        w_s1_nxt.eff_sub = in_eff_sub;
        w_s1_nxt.rm      = in_rm;
        if (in_mant[12]) begin
            w_s1_nxt.mant   = in_mant[12:1];
            w_s1_nxt.sticky = in_sticky | in_mant[0];
            w_s1_nxt.expnt  = {1'b0, in_expnt} + 6'd1;
            w_s1_nxt.onehot = 12'h800;
            w_s1_nxt.den    = 1'b0;
        end else begin
            w_s1_nxt.mant   = in_mant[11:0];
            w_s1_nxt.sticky = in_sticky;
            w_s1_nxt.expnt  = {1'b0, in_expnt};
            w_s1_nxt.onehot = w_lzd_oh;
            w_s1_nxt.den    = w_lzd_den;
        end
    end

    logic [MANT_W-1:0] w_sh;
    logic [EXP_W:0]    w_exp;
    logic [EXP_W:0]    w_expr;
    logic [MANT_W-1:0] w_rnd;
    logic [FRAC_W-1:0] w_frac;
    logic              w_g;
    logic              w_inc;
    logic              w_den_out;
    logic              w_ovf;
    logic              w_nx;
    logic              w_big;
    logic [15:0]       w_res;
    logic [2:0]        w_flg;

    ct_fadd_ohsel_h u_sel (
        .i_data   (r_s1.mant),
        .i_onehot (r_s1.onehot),
        .o_data   (w_sh)
    );

    always_comb begin
        w_exp = r_s1.expnt - {2'b00, oh2amt(r_s1.onehot)};
        w_g   = w_sh[0];
        unique case (r_s1.rm)
            RM_RTZ:  w_inc = 1'b0;
            RM_RDN:  w_inc = r_s1.sign & (w_g | r_s1.sticky);
            RM_RUP:  w_inc = ~r_s1.sign & (w_g | r_s1.sticky);
            RM_RMM:  w_inc = w_g;
            default: w_inc = w_g & (r_s1.sticky | w_sh[1]);
        endcase
        w_rnd = {1'b0, w_sh[11:1]} + {11'b0, w_inc};
        // A denormal whose rounding reaches the hidden bit becomes exp 1.
        if (r_s1.den) begin
            w_expr    = {5'b0, w_rnd[10]};
            w_frac    = w_rnd[9:0];
            w_den_out = ~w_rnd[10];
        end else if (w_rnd[11]) begin
            w_expr    = w_exp + 6'd1;
            w_frac    = w_rnd[10:1];
            w_den_out = 1'b0;
        end else begin
            w_expr    = w_exp;
            w_frac    = w_rnd[9:0];
            w_den_out = 1'b0;
        end
        w_ovf = w_expr >= 6'd31;
        w_nx  = w_g | r_s1.sticky | w_ovf;
        w_big = (r_s1.rm == RM_RTZ)
              | ((r_s1.rm == RM_RDN) & ~r_s1.sign)
              | ((r_s1.rm == RM_RUP) & r_s1.sign);
        if (r_s1.onehot == '0) begin
            w_res = {r_s1.eff_sub ? (r_s1.rm == RM_RDN) : r_s1.sign, 15'h0};
            w_flg = 3'b000;
        end else if (w_ovf) begin
            w_res = (w_big ? FP16_MAXN : FP16_INF) | {r_s1.sign, 15'h0};
            w_flg = 3'b101;
        end else begin
            w_res = {r_s1.sign, w_expr[4:0], w_frac};
            w_flg = {1'b0, w_den_out & w_nx, w_nx};
        end
    end

    always_ff @(posedge cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            r_s1_vld <= 1'b0;
            r_s2_vld <= 1'b0;
        end else if (pipe_flush) begin
            r_s1_vld <= 1'b0;
            r_s2_vld <= 1'b0;
        end else if (!pipe_stall) begin
            r_s1_vld <= in_vld;
            r_s2_vld <= r_s1_vld;
        end
    end

    always_ff @(posedge cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            r_s1    <= '0;
            r_res   <= '0;
            r_flags <= '0;
        end else if (!pipe_stall) begin
            if (in_vld)
                r_s1 <= w_s1_nxt;
            if (r_s1_vld) begin
                r_res   <= w_res;
                r_flags <= w_flg;
            end
        end
    end

    assign out_vld    = r_s2_vld;
    assign out_result = r_res;
    assign out_flags  = r_flags;

endmodule

// File: tb/tb_ct_fadd_norm_round_h.sv
// Bench for the FP16 normalize/round back end: directed vectors plus
// randomized back-to-back traffic against a value-level rounding model.
module tb_ct_fadd_norm_round_h;

    logic        cpuclk = 1'b0;
    logic        cpurst_b = 1'b0;
    logic        pipe_stall = 1'b0;
    logic        pipe_flush = 1'b0;
    logic        in_vld = 1'b0;
    logic        in_sign = 1'b0;
    logic        in_eff_sub = 1'b0;
    logic [4:0]  in_expnt = '0;
    logic [12:0] in_mant = '0;
    logic        in_sticky = 1'b0;
    logic [2:0]  in_rm = '0;
    logic        out_vld;
    logic [15:0] out_result;
    logic [2:0]  out_flags;

    int n_run = 0;
    int n_fail = 0;

    ct_fadd_norm_round_h dut (
        .cpuclk     (cpuclk),
        .cpurst_b   (cpurst_b),
        .pipe_stall (pipe_stall),
        .pipe_flush (pipe_flush),
        .in_vld     (in_vld),
        .in_sign    (in_sign),
        .in_eff_sub (in_eff_sub),
        .in_expnt   (in_expnt),
        .in_mant    (in_mant),
        .in_sticky  (in_sticky),
        .in_rm      (in_rm),
        .out_vld    (out_vld),
        .out_result (out_result),
        .out_flags  (out_flags)
    );

    always #5 cpuclk = ~cpuclk;

    // Value-level model: pick the FP16 exponent of the exact value
    // (clamped at 1), quantise to the FP16 ulp, then round.
    task automatic model(input logic [12:0] m, input logic [4:0] e,
                         input logic s, input logic es, input logic st,
                         input logic [2:0] rm,
                         output logic [15:0] r, output logic [2:0] f);
        int p, ee, sh, q;
        logic g, sk, up, ovf, nx, inf;
        p = -1;
        for (int b = 0; b < 13; b++) if (m[b]) p = b;
        if (p < 0) begin
            r = {(es ? (rm == 3'd2) : s), 15'h0};
            f = 3'b000;
            return;
        end
        ee = int'(e) + p - 11;
        if (ee < 1) ee = 1;
        sh = ee - int'(e) + 1;
        if (sh <= 0) begin
            q = int'(m) << (-sh);
            g = 1'b0;
            sk = st;
        end else begin
            q = int'(m) >> sh;
            g = m[sh-1];
            sk = st | ((int'(m) & ((1 << (sh - 1)) - 1)) != 0);
        end
        case (rm)
            3'd1: up = 1'b0;
            3'd2: up = s & (g | sk);
            3'd3: up = !s & (g | sk);
            3'd4: up = g;
            default: up = g & (sk | q[0]);
        endcase
        q = q + int'(up);
        if (q == 2048) begin
            q = 1024;
            ee = ee + 1;
        end
        ovf = (ee >= 31);
        nx = g | sk | ovf;
        if (ovf) begin
            inf = (rm == 3'd1) ? 1'b0 : (rm == 3'd2) ? s : (rm == 3'd3) ? !s : 1'b1;
            r = inf ? {s, 15'h7C00} : {s, 15'h7BFF};
            f = 3'b101;
        end else begin
            r = {s, (q >= 1024) ? ee[4:0] : 5'd0, q[9:0]};
            f = {1'b0, (q < 1024) & nx, nx};
        end
    endtask

    task automatic drive(input logic v, input logic [12:0] m, input logic [4:0] e,
                         input logic s, input logic es, input logic st,
                         input logic [2:0] rm);
        in_vld = v;
        in_mant = m;
        in_expnt = e;
        in_sign = s;
        in_eff_sub = es;
        in_sticky = st;
        in_rm = rm;
    endtask

    task automatic issue(input logic [12:0] m, input logic [4:0] e,
                         input logic s, input logic es, input logic st,
                         input logic [2:0] rm, output logic ov,
                         output logic [15:0] r, output logic [2:0] f);
        @(posedge cpuclk); #1;
        drive(1'b1, m, e, s, es, st, rm);
        @(posedge cpuclk); #1;
        in_vld = 1'b0;
        @(posedge cpuclk); #1;
        ov = out_vld;
        r = out_result;
        f = out_flags;
    endtask

    task automatic test_reset;
        logic ov;
        logic [15:0] r;
        logic [2:0] f;
        #3;
        n_run++;
        if (out_vld !== 1'b0 || out_result !== 16'h0 || out_flags !== 3'b0) begin
            n_fail++;
            $display("FAIL reset_state: vld=%b res=%h flg=%b required 0/0000/000",
                     out_vld, out_result, out_flags);
        end
        @(posedge cpuclk); #1;
        cpurst_b = 1'b1;
        @(posedge cpuclk); #1;
        drive(1'b1, 13'h1000, 5'd15, 1'b0, 1'b0, 1'b0, 3'd0);
        @(posedge cpuclk); #1;
        in_vld = 1'b0;
        #2 cpurst_b = 1'b0;
        #1;
        n_run++;
        if (out_vld !== 1'b0 || out_result !== 16'h0) begin
            n_fail++;
            $display("FAIL mid_reset: vld=%b res=%h required 0/0000", out_vld, out_result);
        end
        @(posedge cpuclk); #1;
        cpurst_b = 1'b1;
        @(posedge cpuclk); #1;
        n_run++;
        if (out_vld !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_idle: vld=%b required 0", out_vld);
        end
        issue(13'h1000, 5'd15, 1'b0, 1'b0, 1'b0, 3'd0, ov, r, f);
        n_run++;
        if (ov !== 1'b1 || r !== 16'h4000 || f !== 3'b000) begin
            n_fail++;
            $display("FAIL post_reset_op: vld=%b res=%h flg=%b required 1/4000/000", ov, r, f);
        end
    endtask

    task automatic test_directed;
        logic [12:0] tm [12] = '{13'h1000, 13'h0002, 13'h0010, 13'h1FFF, 13'h1FFF,
                                 13'h0803, 13'h0803, 13'h0000, 13'h1FFF, 13'h1FFF,
                                 13'h0003, 13'h07FF};
        logic [4:0]  te [12] = '{5'd15, 5'd15, 5'd3, 5'd30, 5'd30, 5'd15, 5'd15,
                                 5'd15, 5'd30, 5'd30, 5'd1, 5'd1};
        logic        ts [12] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0};
        logic        tx [12] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0};
        logic [2:0]  tr [12] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd0, 3'd1, 3'd2,
                                 3'd2, 3'd3, 3'd0, 3'd0};
        logic [15:0] er [12] = '{16'h4000, 16'h1400, 16'h0020, 16'h7C00, 16'h7BFF,
                                 16'h3C02, 16'h3C01, 16'h8000, 16'hFC00, 16'hFBFF,
                                 16'h0002, 16'h0400};
        logic [2:0]  ef [12] = '{3'b000, 3'b000, 3'b000, 3'b101, 3'b101, 3'b001,
                                 3'b001, 3'b000, 3'b101, 3'b101, 3'b011, 3'b001};
        logic ov;
        logic [15:0] r;
        logic [2:0] f;
        for (int i = 0; i < 12; i++) begin
            issue(tm[i], te[i], ts[i], tx[i], 1'b0, tr[i], ov, r, f);
            n_run++;
            if (ov !== 1'b1 || r !== er[i] || f !== ef[i]) begin
                n_fail++;
                $display("FAIL directed_%0d: vld=%b res=%h flg=%b required 1/%h/%b",
                         i, ov, r, f, er[i], ef[i]);
            end
        end
    endtask

    task automatic test_back_to_back;
        localparam int N = 300;
        logic        ev [N];
        logic [15:0] er [N];
        logic [2:0]  ef [N];
        logic [12:0] m;
        logic [4:0]  e;
        logic        s, es, st, v;
        logic [2:0]  rm;
        for (int i = 0; i < N + 2; i++) begin
            @(posedge cpuclk); #1;
            if (i >= 2) begin
                n_run++;
                if (out_vld !== ev[i-2] ||
                    (ev[i-2] && (out_result !== er[i-2] || out_flags !== ef[i-2]))) begin
                    n_fail++;
                    $display("FAIL random_%0d: vld=%b res=%h flg=%b required %b/%h/%b",
                             i - 2, out_vld, out_result, out_flags,
                             ev[i-2], er[i-2], ef[i-2]);
                end
            end
            if (i < N) begin
                m = 13'($urandom) >> $urandom_range(0, 12);
                e = 5'($urandom_range(1, 30));
                s = 1'($urandom);
                es = 1'($urandom);
                st = ($urandom_range(0, 3) == 0);
                rm = 3'($urandom_range(0, 7));
                v = ($urandom_range(0, 4) != 0);
                drive(v, m, e, s, es, st, rm);
                ev[i] = v;
                model(m, e, s, es, st, rm, er[i], ef[i]);
            end else begin
                in_vld = 1'b0;
            end
        end
    endtask

    task automatic test_stall_flush;
        logic ov;
        logic [15:0] ra, rb;
        logic [2:0] fa, fb;
        logic [15:0] r;
        logic [2:0] f;
        model(13'h0803, 5'd15, 1'b1, 1'b0, 1'b0, 3'd0, ra, fa);
        model(13'h0040, 5'd20, 1'b0, 1'b1, 1'b1, 3'd3, rb, fb);
        issue(13'h0803, 5'd15, 1'b1, 1'b0, 1'b0, 3'd0, ov, r, f);
        pipe_stall = 1'b1;
        drive(1'b1, 13'h0040, 5'd20, 1'b0, 1'b1, 1'b1, 3'd3);
        for (int k = 0; k < 3; k++) begin
            @(posedge cpuclk); #1;
            n_run++;
            if (out_vld !== 1'b1 || out_result !== ra || out_flags !== fa) begin
                n_fail++;
                $display("FAIL stall_hold_%0d: vld=%b res=%h flg=%b required 1/%h/%b",
                         k, out_vld, out_result, out_flags, ra, fa);
            end
        end
        pipe_flush = 1'b1;
        @(posedge cpuclk); #1;
        pipe_flush = 1'b0;
        pipe_stall = 1'b0;
        n_run++;
        if (out_vld !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_in_stall: vld=%b required 0", out_vld);
        end
        @(posedge cpuclk); #1;
        in_vld = 1'b0;
        @(posedge cpuclk); #1;
        n_run++;
        if (out_vld !== 1'b1 || out_result !== rb || out_flags !== fb) begin
            n_fail++;
            $display("FAIL after_release: vld=%b res=%h flg=%b required 1/%h/%b",
                     out_vld, out_result, out_flags, rb, fb);
        end
        drive(1'b1, 13'h1000, 5'd10, 1'b0, 1'b0, 1'b0, 3'd0);
        pipe_flush = 1'b1;
        @(posedge cpuclk); #1;
        pipe_flush = 1'b0;
        in_vld = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(posedge cpuclk); #1;
            n_run++;
            if (out_vld !== 1'b0) begin
                n_fail++;
                $display("FAIL flush_beats_vld_%0d: vld=%b required 0", k, out_vld);
            end
        end
    endtask

    initial begin
        test_reset;
        test_directed;
        test_back_to_back;
        test_stall_flush;
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/ct_fadd_norm_round_h.md
# ct_fadd_norm_round_h

Two-stage pipelined normalize-and-round back end for the half-precision floating-point adder. It takes the raw 13-bit significand sum, exponent and sign from the add stage. It computes the leading-one shift as a denormal-limited one-hot and applies the left shift through the one-hot shift selector. It then rounds per the dynamic rounding mode and delivers a packed FP16 result with exception flags to writeback, under pipeline stall and flush control.

## Interface
Parameters: none; all widths are fixed for FP16.
- cpuclk  in  1  sole clock, rising edge
- cpurst_b  in  1  reset, asynchronous, active-low
- pipe_stall  in  1  hold both stage registers; upstream holds its inputs
- pipe_flush  in  1  kill all in-flight entries
- in_vld  in  1  input entry valid
- in_sign  in  1  sign of the larger operand
- in_eff_sub  in  1  effective subtraction
- in_expnt  in  5  biased exponent of the larger operand; denormal operands enter as 1
- in_mant  in  13  [12] carry-out, [11] hidden bit, [10:1] fraction, [0] guard
- in_sticky  in  1  OR of the bits shifted out below guard
- in_rm  in  3  0 RNE, 1 RTZ, 2 RDN, 3 RUP, 4 RMM; other codes behave as RNE
- out_vld  out  1  result valid
- out_result  out  16  packed FP16 result
- out_flags  out  3  {OF, UF, NX}

## Operation
- Stage 1 (registered at the edge after in_vld):
  - If carry: right-shift by 1; old bit 1 becomes guard; old guard ORs into sticky; exponent+1; shift one-hot = 12'h800.
  - Otherwise: leading-one one-hot of in_mant[11:0]. If the leading-one shift exceeds in_expnt-1, use one-hot bit (11-(in_expnt-1)) and mark the entry denormal.
  - Register: mant12, sticky, exp6 (6 bits, no wrap), onehot12, sign, eff_sub, rm.
- Stage 2 (registered at the next edge):
  - Apply the one-hot left shift; the zero-fill semantics are identical to the shift selector.
  - Exponent = exp6 minus the shift amount; exponent field = 0 if denormal.
  - Round on guard and sticky per rm. Rounding carry out of bit 11 renormalizes: exponent+1, denormal promotes to exponent 1.
  - Pack {sign, exp5, frac10}.
- Zero result (onehot 12'h000 / mant==0): result ±0. Sign = (rm==RDN) if eff_sub, else in_sign. Flags 0.
- Overflow (rounded exponent ≥31): OF=1 and NX=1.
  - Result ±inf for RNE, RMM, and for RUP(+)/RDN(−).
  - Otherwise result 0x7BFF with the sign bit applied.
- NX = guard|sticky at stage 2, or overflow.
- UF = denormal result (after rounding) AND NX.

## Timing
- Latency: 2 cycles; throughput 1 per cycle when not stalled.
- Reset (asynchronous, cpurst_b low): both stage valids 0; out_vld=0, out_result=16'h0000, out_flags=3'b000. Datapath registers also reset to 0.
- pipe_stall=1: no register updates; outputs are held stable.
- pipe_flush=1: both valids clear at the next edge. Flush beats stall and beats a simultaneous in_vld. Data registers are not cleared.
- Reset mid-operation discards everything; the first valid result appears 2 cycles after a post-reset in_vld.
- Data registers load only when the corresponding valid is set, to save power.

## Structure
- Shared package ct_fadd_h_pkg:
  - rounding-mode codes
  - FP16 field widths (EXP_W=5, FRAC_W=10)
  - MANT_W=12
  - constants 0x7C00 and 0x7BFF
- One sub-module: ct_fadd_lzd_h, a combinational 12-bit leading-one detector with exponent limit, producing onehot12 and a denormal flag.
- The stage-2 shift instantiates the existing one-hot shift selector.

## Test plan
- 1.0+1.0: in_mant=13'h1000, expnt=15, RNE → after 2 cycles out_result=16'h4000, flags 000.
- Massive cancellation: in_mant=13'h0002, expnt=15 → shift 10, out_result=16'h1400, flags 000.
- Denormal limit: in_mant=13'h0010, expnt=3 → shift limited to 2, out_result=16'h0020, flags 000 (exact, no UF).
- Overflow: in_mant=13'h1FFF, expnt=30 → RNE gives 16'h7C00 with OF|NX=3'b101; RTZ gives 16'h7BFF with 3'b101.
- Ties-to-even: in_mant=13'h0803, sticky=0, expnt=15 → RNE gives 16'h3C02, NX=1; RTZ gives 16'h3C01.
- Stall/flush: valid entry, then pipe_stall for 3 cycles → out_vld and out_result held. pipe_flush while stalled → out_vld=0 next cycle. Zero sum (in_mant=0, eff_sub=1, RDN) → 16'h8000.
